// File: rtl/alu_op_encoder_pkg.sv
// Shared ALU operation encoding, RV32I opcode constants and skid-buffer states.
// Used by alu_op_encoder and the downstream signed/shift select decode.
package alu_op_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SLT    = 4'b0001,
    OP_BLT    = 4'b0010,
    OP_SLTU   = 4'b0011,
    OP_XOR    = 4'b0100,
    OP_SRL    = 4'b0101,
    OP_OR     = 4'b0110,
    OP_AND    = 4'b0111,
    OP_SUB    = 4'b1000,
    OP_SRA    = 4'b1001,
    OP_SLL    = 4'b1010,
    OP_BLTU   = 4'b1011,
    OP_PASS_B = 4'b1100
  } oper_e;

  typedef struct packed {
    oper_e oper;
    logic  illegal;
  } enc_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  function automatic oper_e alu_f3(input logic [2:0] f3);
    oper_e r;
    unique case (f3)
      3'b000:  r = OP_ADD;
      3'b001:  r = OP_SLL;
      3'b010:  r = OP_SLT;
      3'b011:  r = OP_SLTU;
      3'b100:  r = OP_XOR;
      3'b101:  r = OP_SRL;
      3'b110:  r = OP_OR;
      default: r = OP_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_encoder_if.sv
// Valid/ready bundle between fetch, the ALU op encoder and execute.
interface alu_op_encoder_if;
  logic        i_valid;
  logic [31:0] i_instr;
  logic        o_ready;
  logic        o_valid;
  logic [3:0]  o_oper;
  logic        o_illegal;
  logic        i_ready;

  modport slave (
    input  i_valid, i_instr, i_ready,
    output o_ready, o_valid, o_oper, o_illegal
  );

  modport master (
    output i_valid, i_instr, i_ready,
    input  o_ready, o_valid, o_oper, o_illegal
  );
endinterface

// File: rtl/alu_op_enc_comb.sv
// Combinational RV32I instruction -> {oper, illegal} table.
module alu_op_enc_comb
  import alu_op_pkg::*;
(
  input  logic [31:0] instr,
  output oper_e       oper,
  output logic        illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    oper    = OP_ADD;
    illegal = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE)
          oper = alu_f3(f3);
        else if (f7 == F7_ALT && f3 == 3'b000)
          oper = OP_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)
          oper = OP_SRA;
        else
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        // funct7 only qualifies the shift-immediate forms
        if (f3 == 3'b001 && f7 != F7_BASE)
          illegal = 1'b1;
        else if (f3 == 3'b101 && f7 == F7_ALT)
          oper = OP_SRA;
        else if (f3 == 3'b101 && f7 != F7_BASE)
          illegal = 1'b1;
        else
          oper = alu_f3(f3);
      end
      OPC_BRANCH: begin
        case (f3[2:1])
          2'b00:   oper = OP_SUB;
          2'b10:   oper = OP_BLT;
          2'b11:   oper = OP_BLTU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LUI: oper = OP_PASS_B;
      OPC_LOAD, OPC_STORE, OPC_JAL,
      OPC_JALR, OPC_AUIPC: oper = OP_ADD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_encoder.sv
// ALU op encoder with 2-entry valid/ready skid buffer.
// Define ALU_OP_ENCODER_STATS_EN to add transfer/illegal counters.
module alu_op_encoder
  import alu_op_pkg::*;
#(
  parameter int STAT_W = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_flush,
  alu_op_encoder_if.slave bus
`ifdef ALU_OP_ENCODER_STATS_EN
  ,
  output logic [STAT_W-1:0] o_cnt_ops,
  output logic [STAT_W-1:0] o_cnt_illegal
`endif
);

  oper_e      enc_oper;
  logic       enc_illegal;
  enc_t       enc;
  enc_t       out_q;
  enc_t       skid_q;
  logic [1:0] state;
  logic [1:0] state_n;
  logic       ready_q;
  logic       accept;
  logic       drain;

  alu_op_enc_comb u_enc (
    .instr   (bus.i_instr),
    .oper    (enc_oper),
    .illegal (enc_illegal)
  );

  assign enc           = {enc_oper, enc_illegal};
  assign accept        = bus.i_valid & ready_q;
  assign drain         = bus.o_valid & bus.i_ready;
  assign bus.o_valid   = (state != ST_EMPTY);
  assign bus.o_ready   = ready_q;
  assign bus.o_oper    = out_q.oper;
  assign bus.o_illegal = out_q.illegal;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_EMPTY: if (accept) state_n = ST_ONE;
      ST_ONE: begin
        if (accept && !drain)      state_n = ST_TWO;
        else if (drain && !accept) state_n = ST_EMPTY;
      end
      ST_TWO:  if (drain) state_n = ST_ONE;
      default: state_n = ST_EMPTY;
    endcase
    if (i_flush) state_n = ST_EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n != ST_TWO);
      if (!i_flush) begin
        if (drain && state == ST_TWO)
          out_q <= skid_q;
        else if (accept && (state == ST_EMPTY || drain))
          out_q <= enc;
        if (accept && state == ST_ONE && !drain)
          skid_q <= enc;
      end
    end
  end

`ifdef ALU_OP_ENCODER_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_cnt_ops     <= '0;
      o_cnt_illegal <= '0;
    end else if (drain) begin
      if (o_cnt_ops != '1)
        o_cnt_ops <= o_cnt_ops + 1'b1;
      if (out_q.illegal && o_cnt_illegal != '1)
        o_cnt_illegal <= o_cnt_illegal + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_encoder.sv
// Self-checking bench for alu_op_encoder: directed cases then random traffic
// against a queue-based reference of the instruction stream.
module tb_alu_op_encoder;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_op_encoder_if bus();

`ifdef ALU_OP_ENCODER_STATS_EN
  logic [15:0] cnt_ops;
  logic [15:0] cnt_ill;
`endif

  alu_op_encoder #(.STAT_W(16)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_flush (flush),
    .bus     (bus)
`ifdef ALU_OP_ENCODER_STATS_EN
    ,
    .o_cnt_ops     (cnt_ops),
    .o_cnt_illegal (cnt_ill)
`endif
  );

  // reference: queue of {illegal, oper} entries awaiting downstream transfer
  logic [4:0] q[$];
  logic       m_ready = 1'b0;
  int         m_ops = 0;
  int         m_ill = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_dec(logic [31:0] ins);
    logic [3:0] tab [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    tab = '{4'b0000, 4'b1010, 4'b0001, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111};
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    if (opc == 7'h33) begin
      if (f7 == 7'h00) return {1'b0, tab[f3]};
      if (f7 == 7'h20 && f3 == 3'd0) return 5'b01000;
      if (f7 == 7'h20 && f3 == 3'd5) return 5'b01001;
      return 5'b10000;
    end
    if (opc == 7'h13) begin
      if (f3 == 3'd1) return (f7 == 7'h00) ? 5'b01010 : 5'b10000;
      if (f3 == 3'd5) begin
        if (f7 == 7'h00) return 5'b00101;
        if (f7 == 7'h20) return 5'b01001;
        return 5'b10000;
      end
      return {1'b0, tab[f3]};
    end
    if (opc == 7'h63) begin
      if (f3 == 3'd0 || f3 == 3'd1) return 5'b01000;
      if (f3 == 3'd4 || f3 == 3'd5) return 5'b00010;
      if (f3 == 3'd6 || f3 == 3'd7) return 5'b01011;
      return 5'b10000;
    end
    if (opc == 7'h37) return 5'b01100;
    if (opc == 7'h03 || opc == 7'h23 || opc == 7'h6F ||
        opc == 7'h67 || opc == 7'h17) return 5'b00000;
    return 5'b10000;
  endfunction

  task automatic step(bit v, logic [31:0] ins, bit rdy,
                      bit fl = 1'b0, bit rs = 1'b0);
    bit         acc;
    bit         drn;
    logic [4:0] front;
    bus.i_valid = v;
    bus.i_instr = ins;
    bus.i_ready = rdy;
    flush       = fl;
    rst         = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ready = 1'b0;
      m_ops   = 0;
      m_ill   = 0;
    end else begin
      acc = v && m_ready;
      drn = (q.size() > 0) && rdy;
      if (drn) begin
        front = q.pop_front();
        if (m_ops < 65535) m_ops++;
        if (front[4] && m_ill < 65535) m_ill++;
      end
      if (fl) q.delete();
      else if (acc) q.push_back(ref_dec(ins));
      m_ready = (q.size() < 2);
    end
    #1;
    chk("valid", {31'd0, bus.o_valid}, {31'd0, q.size() > 0});
    chk("ready", {31'd0, bus.o_ready}, {31'd0, m_ready});
    if (q.size() > 0) begin
      chk("oper", {28'd0, bus.o_oper}, {28'd0, q[0][3:0]});
      chk("illegal", {31'd0, bus.o_illegal}, {31'd0, q[0][4]});
    end
`ifdef ALU_OP_ENCODER_STATS_EN
    chk("cnt_ops", {16'd0, cnt_ops}, m_ops);
    chk("cnt_ill", {16'd0, cnt_ill}, m_ill);
`endif
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [10];
    logic [31:0] ins;
    int          sel;
    int          r;
    opcs = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23,
             7'h6F, 7'h67, 7'h17, 7'h37, 7'h00};
    ins = $urandom;
    sel = $urandom_range(0, 9);
    if (sel != 9) ins[6:0] = opcs[sel];
    r = $urandom_range(0, 2);
    if (r == 0) ins[31:25] = 7'h00;
    else if (r == 1) ins[31:25] = 7'h20;
    return ins;
  endfunction

  localparam logic [31:0] ADD  = 32'h003100B3;
  localparam logic [31:0] SRA  = 32'h403150B3;
  localparam logic [31:0] SLTU = 32'h003130B3;
  localparam logic [31:0] BLT  = 32'h00314463;
  localparam logic [31:0] XORI = 32'h0FF14093;
  localparam logic [31:0] BAD  = 32'hFFFFFFFF;

  initial begin
    bus.i_valid = 1'b0;
    bus.i_instr = '0;
    bus.i_ready = 1'b0;
    flush       = 1'b0;
    rst         = 1'b1;

    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, ADD, 1'b1, 1'b0, 1'b1);
    chk("rst_oper", {28'd0, bus.o_oper}, 32'd0);
    chk("rst_illegal", {31'd0, bus.o_illegal}, 32'd0);
    chk("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    step(1'b0, '0, 1'b1);
    chk("post_rst_ready", {31'd0, bus.o_ready}, 32'd1);

    step(1'b1, ADD, 1'b1);
    chk("t1_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("t1_oper", {28'd0, bus.o_oper}, 32'b0000);
    step(1'b0, '0, 1'b1);

    step(1'b1, SRA, 1'b1);
    chk("t2_sra", {28'd0, bus.o_oper}, 32'b1001);
    step(1'b1, SLTU, 1'b1);
    chk("t2_sltu", {28'd0, bus.o_oper}, 32'b0011);
    step(1'b0, '0, 1'b1);

    step(1'b1, BLT, 1'b0);
    chk("t3_blt", {28'd0, bus.o_oper}, 32'b0010);
    step(1'b1, ADD, 1'b0);
    chk("t3_full", {31'd0, bus.o_ready}, 32'd0);
    step(1'b1, XORI, 1'b0);
    chk("t3_hold", {28'd0, bus.o_oper}, 32'b0010);
    step(1'b0, '0, 1'b1);
    chk("t3_second", {28'd0, bus.o_oper}, 32'b0000);
    step(1'b0, '0, 1'b1);
    chk("t3_empty", {31'd0, bus.o_valid}, 32'd0);

    step(1'b1, BAD, 1'b1);
    chk("t4_illegal", {31'd0, bus.o_illegal}, 32'd1);
    chk("t4_oper", {28'd0, bus.o_oper}, 32'd0);
    step(1'b0, '0, 1'b1);
`ifdef ALU_OP_ENCODER_STATS_EN
    chk("t4_cnt_ill", {16'd0, cnt_ill}, 32'd1);
`endif

    step(1'b1, ADD, 1'b0);
    step(1'b1, SRA, 1'b0);
    step(1'b1, XORI, 1'b0, 1'b1);
    chk("t5_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("t5_ready", {31'd0, bus.o_ready}, 32'd1);
    step(1'b1, SLTU, 1'b1, 1'b1);
    chk("t5_flush_wins", {31'd0, bus.o_valid}, 32'd0);
    step(1'b0, '0, 1'b1);

    step(1'b1, BLT, 1'b0);
    step(1'b1, SRA, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t6_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("t6_oper", {28'd0, bus.o_oper}, 32'd0);
`ifdef ALU_OP_ENCODER_STATS_EN
    chk("t6_cnt", {16'd0, cnt_ops}, 32'd0);
`endif
    step(1'b0, '0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
